// File: rtl/rpn_kip_rx_if.sv
// AXI-stream style bundle shared by the KIP receive ports.
// Widths vary per port: full PUB/ACK beats vs. trimmed payload beats.
interface rpn_kip_rx_if #(
  parameter int DW = 512,
  parameter int KW = 64,
  parameter int UW = 64
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic [UW-1:0] tuser;
  logic          tlast;

  modport master (
    output tvalid, tdata, tkeep, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tuser, tlast,
    output tready
  );
endinterface

// File: rtl/rpn_kip_rx.sv
// KIP reliable-publish receiver: per-sender sequence check,
// in-order delivery to the control path and ACK generation.
module rpn_kip_rx #(
  parameter int         NUM_SENDERS     = 16,
  parameter int         AXIS_DATA_WIDTH = 512,
  parameter int         CTID_WIDTH      = 8,
  parameter int         SEQ_WIDTH       = 16,
  parameter logic [7:0] MSG_TYPE_PUB    = 8'h10,
  parameter logic [7:0] MSG_TYPE_ACK    = 8'h11
) (
  input  logic                  i_clk,
  input  logic                  i_ap_rst,
  input  logic [CTID_WIDTH-1:0] i_cluster_id,
  input  logic [15:0]           i_KIP_port_number,
  rpn_kip_rx_if.slave           from_nb,
  rpn_kip_rx_if.master          to_ctrl,
  rpn_kip_rx_if.master          to_nb_KIP
);
  localparam int W  = AXIS_DATA_WIDTH;
  localparam int KW = W / 8;
  localparam int PW = W - 32;
  localparam int IW = (NUM_SENDERS > 1) ? $clog2(NUM_SENDERS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    CHECK,
    DELIVER,
    SEND_ACK
  } state_t;

  state_t                state;
  logic [7:0]            typ;
  logic [CTID_WIDTH-1:0] ctid;
  logic [SEQ_WIDTH-1:0]  seq;
  logic [PW-1:0]         payload;
  logic [KW-1:0]         keep;
  logic [31:0]           src_ip;

  logic [SEQ_WIDTH-1:0]   exp_seq [NUM_SENDERS];
  logic [NUM_SENDERS-1:0] seen;

  logic in_rdy;
  logic ctrl_vld;
  logic ack_vld;

  logic [IW-1:0]        idx;
  logic [SEQ_WIDTH-1:0] exp_cur;
  logic [SEQ_WIDTH-1:0] exp_prev;
  logic                 bad;
  logic [W-1:0]         ack_data;
  logic                 unused_bits;

  assign idx      = ctid[IW-1:0];
  assign exp_cur  = exp_seq[idx];
  assign exp_prev = exp_cur - 1'b1;
  assign bad      = (typ != MSG_TYPE_PUB) ||
                    (ctid >= CTID_WIDTH'(NUM_SENDERS));

  // Ports in the WAN tuser are not needed; ACK uses the KIP port.
  assign unused_bits = ^from_nb.tuser[63:32];

  always_comb begin
    ack_data                  = '0;
    ack_data[7:0]             = MSG_TYPE_ACK;
    ack_data[8+:CTID_WIDTH]   = i_cluster_id;
    ack_data[16+:SEQ_WIDTH]   = seq;
  end

  always_ff @(posedge i_clk or posedge i_ap_rst) begin
    if (i_ap_rst) begin
      state    <= IDLE;
      typ      <= '0;
      ctid     <= '0;
      seq      <= '0;
      payload  <= '0;
      keep     <= '0;
      src_ip   <= '0;
      seen     <= '0;
      in_rdy   <= 1'b1;
      ctrl_vld <= 1'b0;
      ack_vld  <= 1'b0;
      for (int i = 0; i < NUM_SENDERS; i++) begin
        exp_seq[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (from_nb.tvalid && in_rdy) begin
            typ     <= from_nb.tdata[7:0];
            ctid    <= from_nb.tdata[8+:CTID_WIDTH];
            seq     <= from_nb.tdata[16+:SEQ_WIDTH];
            payload <= from_nb.tdata[W-1:32];
            keep    <= from_nb.tkeep;
            src_ip  <= from_nb.tuser[31:0];
            if (from_nb.tlast) begin
              state  <= CHECK;
              in_rdy <= 1'b0;
            end else begin
              state  <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (from_nb.tvalid && in_rdy && from_nb.tlast) begin
            state  <= CHECK;
            in_rdy <= 1'b0;
          end
        end
        CHECK: begin
          if (bad) begin
            state  <= IDLE;
            in_rdy <= 1'b1;
          end else if (seq == exp_cur) begin
            state    <= DELIVER;
            ctrl_vld <= 1'b1;
          end else if (seen[idx] && seq == exp_prev) begin
            state   <= SEND_ACK;
            ack_vld <= 1'b1;
          end else begin
            state  <= IDLE;
            in_rdy <= 1'b1;
          end
        end
        DELIVER: begin
          // Table advances only once the payload has really left.
          if (to_ctrl.tready) begin
            ctrl_vld     <= 1'b0;
            ack_vld      <= 1'b1;
            exp_seq[idx] <= exp_cur + 1'b1;
            seen[idx]    <= 1'b1;
            state        <= SEND_ACK;
          end
        end
        SEND_ACK: begin
          if (to_nb_KIP.tready) begin
            ack_vld <= 1'b0;
            in_rdy  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          in_rdy <= 1'b1;
        end
      endcase
    end
  end

  assign from_nb.tready = in_rdy;

  assign to_ctrl.tvalid = ctrl_vld;
  assign to_ctrl.tdata  = payload;
  assign to_ctrl.tkeep  = keep;
  assign to_ctrl.tuser  = {ctid, src_ip};
  assign to_ctrl.tlast  = 1'b1;

  assign to_nb_KIP.tvalid = ack_vld;
  assign to_nb_KIP.tdata  = ack_data;
  assign to_nb_KIP.tkeep  = {{(KW-4){1'b0}}, 4'hF};
  assign to_nb_KIP.tuser  = {i_KIP_port_number,
                             i_KIP_port_number, src_ip};
  assign to_nb_KIP.tlast  = 1'b1;
endmodule
